// File: rtl/esp32_spi_pkg.sv
// Shared constants, FSM state type and frame-length helper for the ESP32 SPI feedback link.
// ESP32_SPI_FEEDBACK_CHECKSUM_EN adds a trailing checksum byte to every frame.
package esp32_spi_pkg;

    localparam logic [7:0] HDR_FRESH = 8'hA5;
    localparam logic [7:0] HDR_IDLE  = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_e;

    // Header byte + payload, plus the checksum byte when enabled.
    function automatic int unsigned frame_len(input int unsigned payload_bits);
`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
        return 16 + payload_bits;
`else
        return 8 + payload_bits;
`endif
    endfunction

endpackage

// File: rtl/esp32_spi_feedback_tx_if.sv
// Valid/ready command bus that queues one feedback payload into the transmitter.
interface esp32_spi_feedback_tx_if #(
    parameter int unsigned PAYLOAD_BITS = 16
) ();

    logic [PAYLOAD_BITS-1:0] cmd_data;
    logic                    cmd_valid;
    logic                    cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/spi_edge_detect.sv
// Registers a synchronized level and flags its rising and falling edges.
module spi_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise_c,
    output logic fall_c
);

    logic prev_q;
    logic prev_d;

    assign prev_d = sig;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= RESET_VAL;
        else          prev_q <= prev_d;
    end

    assign rise_c = sig & ~prev_q;
    assign fall_c = ~sig & prev_q;

endmodule

// File: rtl/esp32_spi_feedback_tx.sv
// SPI-slave feedback transmitter: shifts {header, payload[, checksum]} out on MISO, MSB first.
// ESP32_SPI_FEEDBACK_CHECKSUM_EN appends a zero-sum checksum byte computed at frame load.
module esp32_spi_feedback_tx
    import esp32_spi_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   spi_csn,
    input  logic                   spi_clk,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    esp32_spi_feedback_tx_if.slave cmd,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_abort
);

    localparam int unsigned FRAME_LEN = frame_len(PAYLOAD_BITS);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    logic sck_rise_c, sck_fall_c, csn_rise_c, csn_fall_c;

    spi_edge_detect #(.RESET_VAL(1'b0)) u_sck_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (spi_clk),
        .rise_c  (sck_rise_c),
        .fall_c  (sck_fall_c)
    );

    spi_edge_detect #(.RESET_VAL(1'b1)) u_csn_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (spi_csn),
        .rise_c  (csn_rise_c),
        .fall_c  (csn_fall_c)
    );

    state_e                  state_q,   state_d;
    logic [FRAME_LEN-1:0]    shreg_q,   shreg_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [PAYLOAD_BITS-1:0] hold_q,    hold_d;
    logic                    full_q,    full_d;
    logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
    logic                    fresh_q,   fresh_d;
    logic                    oe_q,      oe_d;
    logic                    done_q,    done_d;
    logic                    abort_q,   abort_d;
    logic                    ready_q,   ready_d;

    logic                    accept_c;
    logic [7:0]              hdr_c;
    logic [PAYLOAD_BITS-1:0] load_payload_c;
    logic [FRAME_LEN-1:0]    frame_c;

`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
    // Byte chosen so header + payload bytes + checksum sums to 0 mod 256.
    function automatic logic [7:0] frame_csum(input logic [7:0] hdr,
                                              input logic [PAYLOAD_BITS-1:0] pl);
        logic [7:0] sum;
        sum = hdr;
        for (int unsigned i = 0; i < PAYLOAD_BITS / 8; i++) begin
            sum = sum + pl[i*8 +: 8];
        end
        return 8'(8'd0 - sum);
    endfunction
`endif

    assign accept_c       = cmd.cmd_valid & ready_q;
    assign hdr_c          = full_q ? HDR_FRESH : HDR_IDLE;
    assign load_payload_c = full_q ? hold_q : '0;

`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
    assign frame_c = {hdr_c, load_payload_c, frame_csum(hdr_c, load_payload_c)};
`else
    assign frame_c = {hdr_c, load_payload_c};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            payload_q <= '0;
            fresh_q   <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            payload_q <= payload_d;
            fresh_q   <= fresh_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        full_d    = full_q;
        payload_d = payload_q;
        fresh_d   = fresh_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (csn_fall_c) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = frame_c;
                    cnt_d     = '0;
                    oe_d      = 1'b1;
                    fresh_d   = full_q;
                    payload_d = load_payload_c;
                    full_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (csn_rise_c) begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    oe_d    = 1'b0;
                    abort_d = 1'b1;
                    // Requeue an aborted fresh payload only if nothing newer is waiting.
                    if (fresh_q && !full_q) begin
                        hold_d = payload_q;
                        full_d = 1'b1;
                    end
                end else begin
                    if (sck_fall_c) begin
                        shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
                    end
                    if (sck_rise_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            state_d = ST_TAIL;
                            shreg_d = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_TAIL: begin
                if (csn_rise_c) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept after the load so a same-cycle word stays held for the next frame.
        if (accept_c) begin
            hold_d = cmd.cmd_data;
            full_d = 1'b1;
        end
    end

    assign ready_d = ~full_d;

    assign spi_miso      = shreg_q[FRAME_LEN-1];
    assign spi_miso_oe   = oe_q;
    assign busy          = oe_q;
    assign frame_done    = done_q;
    assign frame_abort   = abort_q;
    assign cmd.cmd_ready = ready_q;

endmodule

// File: tb/tb_esp32_spi_feedback_tx.sv
// Directed bench for esp32_spi_feedback_tx: acts as the ESP32 SPI master and checks MISO frames.
module tb_esp32_spi_feedback_tx;

    localparam int unsigned PB = 16;
`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
    localparam int NBITS = 32;
`else
    localparam int NBITS = 24;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic spi_csn = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_miso, spi_miso_oe, busy, frame_done, frame_abort;

    esp32_spi_feedback_tx_if #(.PAYLOAD_BITS(PB)) cmd_if ();

    esp32_spi_feedback_tx #(.PAYLOAD_BITS(PB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_csn     (spi_csn),
        .spi_clk     (spi_clk),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .cmd         (cmd_if),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    bit ready_low_seen = 1'b0;

    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    // Expected MISO bit stream, right-aligned in 32 bits.
    function automatic logic [31:0] exp_frame(input logic [7:0] hdr, input logic [15:0] pl);
`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
        logic [7:0] s;
        s = hdr + pl[15:8] + pl[7:0];
        return {hdr, pl, 8'(8'd0 - s)};
`else
        return {8'h00, hdr, pl};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (!cmd_if.cmd_ready) ready_low_seen = 1'b1;
    endtask

    task automatic queue_word(input logic [15:0] d);
        int w = 0;
        while (!cmd_if.cmd_ready && w < 20) begin
            step();
            w++;
        end
        if (!cmd_if.cmd_ready) begin
            n_checks++;
            $display("FAIL queue_wait: cmd_ready still %b after %0d clk, want 1", cmd_if.cmd_ready, w);
        end
        cmd_if.cmd_data  = d;
        cmd_if.cmd_valid = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b0)
            $display("FAIL ready_after_accept: got %b want 0", cmd_if.cmd_ready);
        else n_pass++;
    endtask

    // Master-side frame: nrise SCK periods at clk/8, optional same-cycle or mid-frame queueing.
    task automatic run_frame(input int nrise, input bit sim_en, input logic [15:0] sim_data,
                             input int mid_at, input logic [15:0] mid_data,
                             output logic [31:0] cap);
        cap = '0;
        spi_csn = 1'b0;
        if (sim_en) begin
            cmd_if.cmd_data  = sim_data;
            cmd_if.cmd_valid = 1'b1;
        end
        step();
        cmd_if.cmd_valid = 1'b0;
        repeat (5) step();
        for (int i = 0; i < nrise; i++) begin
            cap = {cap[30:0], spi_miso};
            spi_clk = 1'b1;
            repeat (4) step();
            spi_clk = 1'b0;
            if (i + 1 == mid_at) begin
                cmd_if.cmd_data  = mid_data;
                cmd_if.cmd_valid = 1'b1;
                step();
                cmd_if.cmd_valid = 1'b0;
                repeat (3) step();
            end else begin
                repeat (4) step();
            end
        end
        repeat (2) step();
        spi_csn = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (spi_miso    !== 1'b0) $display("FAIL rst_miso: got %b want 0", spi_miso);       else n_pass++;
        n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", spi_miso_oe);      else n_pass++;
        n_checks++; if (busy        !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);           else n_pass++;
        n_checks++; if (frame_done  !== 1'b0) $display("FAIL rst_done: got %b want 0", frame_done);     else n_pass++;
        n_checks++; if (frame_abort !== 1'b0) $display("FAIL rst_abort: got %b want 0", frame_abort);   else n_pass++;
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", cmd_if.cmd_ready); else n_pass++;
        reset_n = 1'b1;
        #2;
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL ready_pre_edge: got %b want 0", cmd_if.cmd_ready); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL ready_post_edge: got %b want 1", cmd_if.cmd_ready); else n_pass++;
    endtask

    task automatic test_fresh_frame();
        logic [31:0] cap;
        int d0, a0;
        queue_word(16'h1234);
        d0 = done_cnt; a0 = abort_cnt;
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'hA5, 16'h1234)) $display("FAIL fresh_bits: got %h want %h", cap, exp_frame(8'hA5, 16'h1234)); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL fresh_done: got %0d pulses want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (abort_cnt - a0 !== 0) $display("FAIL fresh_abort: got %0d pulses want 0", abort_cnt - a0); else n_pass++;
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL fresh_ready: got %b want 1", cmd_if.cmd_ready); else n_pass++;
        n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL fresh_oe_off: got %b want 0", spi_miso_oe); else n_pass++;
    endtask

    task automatic test_idle_frame();
        logic [31:0] cap;
        int d0;
        d0 = done_cnt;
        ready_low_seen = 1'b0;
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'h5A, 16'h0000)) $display("FAIL idle_bits: got %h want %h", cap, exp_frame(8'h5A, 16'h0000)); else n_pass++;
        n_checks++; if (ready_low_seen !== 1'b0) $display("FAIL idle_ready: got low=%b want 0", ready_low_seen); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL idle_done: got %0d pulses want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_abort_retx();
        logic [31:0] cap;
        int d0, a0;
        queue_word(16'hBEEF);
        d0 = done_cnt; a0 = abort_cnt;
        run_frame(10, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (abort_cnt - a0 !== 1) $display("FAIL abort_pulse: got %0d pulses want 1", abort_cnt - a0); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'hA5, 16'hBEEF)) $display("FAIL retx_bits: got %h want %h", cap, exp_frame(8'hA5, 16'hBEEF)); else n_pass++;
    endtask

    task automatic test_abort_newer();
        logic [31:0] cap;
        int a0;
        queue_word(16'hBEEF);
        a0 = abort_cnt;
        run_frame(10, 1'b0, 16'h0, 5, 16'hCAFE, cap);
        n_checks++; if (abort_cnt - a0 !== 1) $display("FAIL newer_abort: got %0d pulses want 1", abort_cnt - a0); else n_pass++;
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'hA5, 16'hCAFE)) $display("FAIL newer_bits: got %h want %h", cap, exp_frame(8'hA5, 16'hCAFE)); else n_pass++;
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'h5A, 16'h0000)) $display("FAIL newer_no_resend: got %h want %h", cap, exp_frame(8'h5A, 16'h0000)); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] cap;
        run_frame(NBITS, 1'b1, 16'h00FF, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'h5A, 16'h0000)) $display("FAIL sim_cur_bits: got %h want %h", cap, exp_frame(8'h5A, 16'h0000)); else n_pass++;
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL sim_held: ready got %b want 0", cmd_if.cmd_ready); else n_pass++;
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'hA5, 16'h00FF)) $display("FAIL sim_next_bits: got %h want %h", cap, exp_frame(8'hA5, 16'h00FF)); else n_pass++;
    endtask

`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] cap;
        queue_word(16'h1234);
        run_frame(32, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== 32'hA5123415) $display("FAIL csum_bits: got %h want a5123415", cap); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] cap;
        queue_word(16'h1234);
        spi_csn = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 2; i++) begin
            spi_clk = 1'b1;
            repeat (4) step();
            spi_clk = 1'b0;
            repeat (4) step();
        end
        n_checks++; if (spi_miso !== 1'b1) $display("FAIL mid_pre_miso: got %b want 1", spi_miso); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_pre_busy: got %b want 1", busy); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL mid_rst_oe: got %b want 0", spi_miso_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (spi_miso !== 1'b0) $display("FAIL mid_rst_miso: got %b want 0", spi_miso); else n_pass++;
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", cmd_if.cmd_ready); else n_pass++;
        spi_csn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) step();
        run_frame(NBITS, 1'b0, 16'h0, -1, 16'h0, cap);
        n_checks++; if (cap !== exp_frame(8'h5A, 16'h0000)) $display("FAIL mid_lost_bits: got %h want %h", cap, exp_frame(8'h5A, 16'h0000)); else n_pass++;
    endtask

    initial begin
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_valid = 1'b0;
        test_reset();
        test_fresh_frame();
        test_idle_frame();
        test_abort_retx();
        test_abort_newer();
        test_simultaneous();
`ifdef ESP32_SPI_FEEDBACK_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
